// File: rtl/lsq_multi_cdb.sv
`default_nettype none
// ============================================================================
//  Module   : lsq_multi_cdb
//  Brief    : In-order load/store queue. Operands are snooped from N result
//             broadcast channels. Ops execute strictly from the head, loads are
//             sign/zero extended, and a flush keeps committed stores.
//  Revision : 1.0  initial release
// ============================================================================
module lsq_multi_cdb #(
  parameter int LSQ_WIDTH    = 3,
  parameter int LSQ_SIZE     = 2**LSQ_WIDTH,
  parameter int ROB_WIDTH    = 4,
  parameter int CDB_PORTS    = 3,
  parameter int FULL_RESERVE = 1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           clear_in,
  input  logic                           issue_signal,
  input  logic                           issue_wr,
  input  logic                           issue_signed,
  input  logic [1:0]                     issue_len,
  input  logic [31:0]                    issue_base,
  input  logic                           issue_base_valid,
  input  logic [ROB_WIDTH-1:0]           issue_base_tag,
  input  logic [31:0]                    issue_data,
  input  logic                           issue_data_valid,
  input  logic [ROB_WIDTH-1:0]           issue_data_tag,
  input  logic [11:0]                    issue_offset,
  input  logic [ROB_WIDTH-1:0]           issue_rd_tag,
  input  logic                           commit_signal,
  input  logic [ROB_WIDTH-1:0]           commit_tag,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]        cdb_value,
  output logic                           mem_signal,
  output logic                           mem_wr,
  output logic [1:0]                     mem_len,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_dout,
  input  logic [31:0]                    mem_din,
  input  logic                           mem_done,
  output logic                           done_signal,
  output logic [31:0]                    done_value,
  output logic [ROB_WIDTH-1:0]           done_tag,
  output logic [LSQ_WIDTH:0]             count,
  output logic                           full
);

  localparam logic [0:0]         c_S_IDLE  = 1'b0;
  localparam logic [0:0]         c_S_REQ   = 1'b1;
  localparam logic [LSQ_WIDTH:0] c_SIZE    = (LSQ_WIDTH+1)'(LSQ_SIZE);
  localparam logic [LSQ_WIDTH:0] c_RESERVE = (LSQ_WIDTH+1)'(FULL_RESERVE);

  // Entry storage
  logic [LSQ_SIZE-1:0]  r_busy, r_wr, r_signed, r_base_valid, r_data_valid, r_committed;
  logic [1:0]           r_len      [LSQ_SIZE];
  logic [31:0]          r_base     [LSQ_SIZE];
  logic [31:0]          r_data     [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] r_base_tag [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] r_data_tag [LSQ_SIZE];
  logic [ROB_WIDTH-1:0] r_rd_tag   [LSQ_SIZE];
  logic [11:0]          r_offset   [LSQ_SIZE];

  logic [LSQ_WIDTH-1:0] r_head, r_tail;
  logic [LSQ_WIDTH:0]   r_count;
  logic [0:0]           r_state, w_state_next;
  logic                 r_mem_signed;
  logic [ROB_WIDTH-1:0] r_mem_tag;

  logic [LSQ_SIZE-1:0]  w_head_sel, w_tail_sel, w_commit_hit, w_keep;
  logic [LSQ_SIZE-1:0]  w_base_hit, w_data_hit;
  logic [31:0]          w_base_snoop [LSQ_SIZE];
  logic [31:0]          w_data_snoop [LSQ_SIZE];
  logic [LSQ_WIDTH:0]   w_keep_cnt;
  logic                 w_iss_base_hit, w_iss_data_hit;
  logic [31:0]          w_iss_base, w_iss_data;
  logic [32:0]          w_iss_base_snoop, w_iss_data_snoop;
  logic                 w_flush, w_push, w_pop, w_launch, w_head_ready;
  logic [31:0]          w_eff_addr, w_load_ext;

  // Look up a tag on all broadcast channels plus our own load result; the
  // lowest-numbered matching channel wins, own result has lowest priority.
  function automatic logic [32:0] snoop(
    input logic [ROB_WIDTH-1:0]           tag,
    input logic [CDB_PORTS-1:0]           v,
    input logic [CDB_PORTS*ROB_WIDTH-1:0] t,
    input logic [CDB_PORTS*32-1:0]        d,
    input logic                           dv,
    input logic [ROB_WIDTH-1:0]           dt,
    input logic [31:0]                    dval
  );
    logic [32:0] w_res;
    w_res = '0;
    if (dv && (dt == tag)) w_res = {1'b1, dval};
    for (int k = CDB_PORTS - 1; k >= 0; k--) begin
      if (v[k] && (t[k*ROB_WIDTH +: ROB_WIDTH] == tag)) w_res = {1'b1, d[k*32 +: 32]};
    end
    return w_res;
  endfunction

  assign w_flush = rdy_in & clear_in;
  assign w_push  = rdy_in & issue_signal & ~clear_in & (r_count != c_SIZE);
  // A load in flight is withdrawn by a flush; a store always completes.
  assign w_pop   = rdy_in & (r_state == c_S_REQ) & mem_done & ~(clear_in & ~mem_wr);

  assign w_head_ready = r_busy[r_head] & r_base_valid[r_head] &
                        (~r_wr[r_head] | (r_data_valid[r_head] & r_committed[r_head]));
  assign w_launch     = rdy_in & ~clear_in & (r_state == c_S_IDLE) & w_head_ready;
  assign w_eff_addr   = r_base[r_head] + {{20{r_offset[r_head][11]}}, r_offset[r_head]};

  assign w_iss_base_snoop = snoop(issue_base_tag, cdb_valid, cdb_tag, cdb_value,
                                  done_signal, done_tag, done_value);
  assign w_iss_data_snoop = snoop(issue_data_tag, cdb_valid, cdb_tag, cdb_value,
                                  done_signal, done_tag, done_value);
  assign w_iss_base_hit   = issue_base_valid | w_iss_base_snoop[32];
  assign w_iss_data_hit   = issue_data_valid | w_iss_data_snoop[32];
  assign w_iss_base       = issue_base_valid ? issue_base : w_iss_base_snoop[31:0];
  assign w_iss_data       = issue_data_valid ? issue_data : w_iss_data_snoop[31:0];

  assign count = r_count;
  assign full  = (c_SIZE - r_count) <= c_RESERVE;

  // Per-entry decode: index selects, operand snoop, commit match, flush survivors
  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < LSQ_SIZE; i++) begin
      w_head_sel[i]   = (r_head == LSQ_WIDTH'(i));
      w_tail_sel[i]   = (r_tail == LSQ_WIDTH'(i));
      {w_base_hit[i], w_base_snoop[i]} = snoop(r_base_tag[i], cdb_valid, cdb_tag, cdb_value,
                                               done_signal, done_tag, done_value);
      {w_data_hit[i], w_data_snoop[i]} = snoop(r_data_tag[i], cdb_valid, cdb_tag, cdb_value,
                                               done_signal, done_tag, done_value);
      w_commit_hit[i] = commit_signal & r_busy[i] & r_wr[i] & (r_rd_tag[i] == commit_tag);
      w_keep[i]       = r_busy[i] & r_wr[i] & (r_committed[i] | w_commit_hit[i]);
      w_keep_cnt      = w_keep_cnt + {{LSQ_WIDTH{1'b0}}, w_keep[i]};
    end
  end

  // Sign/zero extension of the returned memory word
  always_comb begin
    case (mem_len)
      2'b00:   w_load_ext = r_mem_signed ? {{24{mem_din[7]}}, mem_din[7:0]}
                                         : {24'b0, mem_din[7:0]};
      2'b01:   w_load_ext = r_mem_signed ? {{16{mem_din[15]}}, mem_din[15:0]}
                                         : {16'b0, mem_din[15:0]};
      default: w_load_ext = mem_din;
    endcase
  end

  // Entry array: issue write, operand capture, commit marking, pop and flush
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy       <= '0;
      r_wr         <= '0;
      r_signed     <= '0;
      r_base_valid <= '0;
      r_data_valid <= '0;
      r_committed  <= '0;
      for (int i = 0; i < LSQ_SIZE; i++) begin
        r_len[i]      <= '0;
        r_base[i]     <= '0;
        r_data[i]     <= '0;
        r_base_tag[i] <= '0;
        r_data_tag[i] <= '0;
        r_rd_tag[i]   <= '0;
        r_offset[i]   <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (w_flush) begin
          r_busy[i] <= w_keep[i] & ~(w_pop & w_head_sel[i]);
          if (w_commit_hit[i]) r_committed[i] <= 1'b1;
        end else if (w_push && w_tail_sel[i]) begin
          r_busy[i]       <= 1'b1;
          r_wr[i]         <= issue_wr;
          r_signed[i]     <= issue_signed;
          r_len[i]        <= issue_len;
          r_base_valid[i] <= w_iss_base_hit;
          r_base[i]       <= w_iss_base;
          r_base_tag[i]   <= issue_base_tag;
          r_data_valid[i] <= w_iss_data_hit;
          r_data[i]       <= w_iss_data;
          r_data_tag[i]   <= issue_data_tag;
          r_offset[i]     <= issue_offset;
          r_rd_tag[i]     <= issue_rd_tag;
          r_committed[i]  <= 1'b0;
        end else begin
          if (w_pop && w_head_sel[i]) r_busy[i] <= 1'b0;
          if (r_busy[i] && !r_base_valid[i] && w_base_hit[i]) begin
            r_base_valid[i] <= 1'b1;
            r_base[i]       <= w_base_snoop[i];
          end
          if (r_busy[i] && !r_data_valid[i] && w_data_hit[i]) begin
            r_data_valid[i] <= 1'b1;
            r_data[i]       <= w_data_snoop[i];
          end
          if (w_commit_hit[i]) r_committed[i] <= 1'b1;
        end
      end
    end
  end

  // Queue pointers, occupancy, memory request fields and load result
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      mem_wr       <= 1'b0;
      mem_len      <= 2'b00;
      mem_addr     <= '0;
      mem_dout     <= '0;
      r_mem_signed <= 1'b0;
      r_mem_tag    <= '0;
      done_signal  <= 1'b0;
      done_value   <= '0;
      done_tag     <= '0;
    end else if (rdy_in) begin
      r_head <= r_head + LSQ_WIDTH'(w_pop);
      if (w_flush) begin
        // Surviving committed stores sit contiguously from the head.
        r_tail  <= r_head + w_keep_cnt[LSQ_WIDTH-1:0];
        r_count <= w_keep_cnt - (LSQ_WIDTH+1)'(w_pop);
      end else begin
        r_tail  <= r_tail + LSQ_WIDTH'(w_push);
        r_count <= r_count + (LSQ_WIDTH+1)'(w_push) - (LSQ_WIDTH+1)'(w_pop);
      end
      if (w_launch) begin
        mem_wr       <= r_wr[r_head];
        mem_len      <= r_len[r_head];
        mem_addr     <= w_eff_addr;
        mem_dout     <= r_data[r_head];
        r_mem_signed <= r_signed[r_head];
        r_mem_tag    <= r_rd_tag[r_head];
      end
      done_signal <= w_pop & ~mem_wr & ~w_flush;
      if (w_pop && !mem_wr) begin
        done_value <= w_load_ext;
        done_tag   <= r_mem_tag;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= c_S_IDLE;
    else           r_state <= w_state_next;
  end

  // FSM next state: launch from IDLE, leave REQ on completion or load withdrawal
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE: if (w_launch) w_state_next = c_S_REQ;
      c_S_REQ:  if (rdy_in && (mem_done || (clear_in && !mem_wr))) w_state_next = c_S_IDLE;
      default:  w_state_next = c_S_IDLE;
    endcase
  end

  // FSM output: request is valid for the whole REQ state
  always_comb begin
    mem_signal = (r_state == c_S_REQ);
  end

  // Pushing into a completely full queue is an issue-stage bug
  a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(rdy_in && issue_signal && !clear_in && (r_count == c_SIZE)));

endmodule
`default_nettype wire

// File: tb/tb_lsq_multi_cdb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsq_multi_cdb
//  Brief    : Scoreboard bench for lsq_multi_cdb. Expected memory requests and
//             load results are queued at issue time and checked by monitors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsq_multi_cdb;
  localparam int LW = 3;
  localparam int RW = 4;
  localparam int CP = 3;

  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, clear_in, issue_signal, issue_wr, issue_signed;
  logic [1:0] issue_len;
  logic [31:0] issue_base, issue_data;
  logic issue_base_valid, issue_data_valid;
  logic [RW-1:0] issue_base_tag, issue_data_tag, issue_rd_tag, commit_tag;
  logic [11:0] issue_offset;
  logic commit_signal;
  logic [CP-1:0] cdb_valid;
  logic [CP*RW-1:0] cdb_tag;
  logic [CP*32-1:0] cdb_value;
  logic mem_signal, mem_wr, mem_done, done_signal, full;
  logic [1:0] mem_len;
  logic [31:0] mem_addr, mem_dout, mem_din, done_value;
  logic [RW-1:0] done_tag;
  logic [LW:0] count;

  lsq_multi_cdb #(.LSQ_WIDTH(LW), .LSQ_SIZE(8), .ROB_WIDTH(RW), .CDB_PORTS(CP), .FULL_RESERVE(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_signal(issue_signal), .issue_wr(issue_wr), .issue_signed(issue_signed),
    .issue_len(issue_len), .issue_base(issue_base), .issue_base_valid(issue_base_valid),
    .issue_base_tag(issue_base_tag), .issue_data(issue_data), .issue_data_valid(issue_data_valid),
    .issue_data_tag(issue_data_tag), .issue_offset(issue_offset), .issue_rd_tag(issue_rd_tag),
    .commit_signal(commit_signal), .commit_tag(commit_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .mem_signal(mem_signal), .mem_wr(mem_wr),
    .mem_len(mem_len), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_done(mem_done), .done_signal(done_signal), .done_value(done_value),
    .done_tag(done_tag), .count(count), .full(full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] din;
    logic [3:0]  tag;
    logic        sgn;
  } op_t;
  typedef struct {
    logic [31:0] val;
    logic [3:0]  tag;
  } done_t;

  op_t   sb_q[$];
  done_t done_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    auto_mem = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference extension: take the low byte/half as a number, subtract the
  // range when signed and the top bit is set.
  function automatic logic [31:0] model_load(input logic [31:0] din, input logic [1:0] len, input logic sgn);
    longint v;
    v = din;
    if (len == 2'b00) begin
      v = v % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (len == 2'b01) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] base, input logic [11:0] off);
    longint o, s;
    o = off;
    if (o >= 2048) o = o - 4096;
    s = longint'(base) + o;
    return s[31:0];
  endfunction

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic wr, input logic sgn, input logic [1:0] len,
                           input logic [31:0] base, input logic bv, input logic [3:0] btag,
                           input logic [31:0] data, input logic dv, input logic [3:0] dtag,
                           input logic [11:0] off, input logic [3:0] rd);
    issue_signal = 1'b1; issue_wr = wr; issue_signed = sgn; issue_len = len;
    issue_base = base; issue_base_valid = bv; issue_base_tag = btag;
    issue_data = data; issue_data_valid = dv; issue_data_tag = dtag;
    issue_offset = off; issue_rd_tag = rd;
  endtask

  task automatic expect_op(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] dout, input logic [31:0] din, input logic [3:0] tag,
                           input logic sgn);
    op_t e;
    e.wr = wr; e.len = len; e.addr = addr; e.dout = dout; e.din = din; e.tag = tag; e.sgn = sgn;
    sb_q.push_back(e);
  endtask

  task automatic commit(input logic [3:0] tag);
    commit_signal = 1'b1; commit_tag = tag;
    tick;
    commit_signal = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((count != 0 || mem_signal || sb_q.size() != 0) && n < budget) begin
      tick;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got count=%0d pending=%0d expected drained", name, count, sb_q.size());
    end
    repeat (3) tick;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (mem_signal !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk(name, mem_signal, 1);
  endtask

  // Memory responder: checks each request against the scoreboard, then
  // completes it after a random delay and queues the expected load result.
  initial begin
    op_t e;
    int  d;
    forever begin
      @(negedge clk_in);
      if (auto_mem && mem_signal === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%08h expected no request", mem_addr);
          e.wr = 1'b1; e.din = '0;
        end else begin
          e = sb_q.pop_front();
          chk("req_wr", mem_wr, e.wr);
          chk("req_len", mem_len, e.len);
          chk("req_addr", mem_addr, e.addr);
          if (e.wr) chk("req_dout", mem_dout, e.dout);
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk_in);
          chk("req_hold", mem_signal, 1);
        end
        @(posedge clk_in);
        #1;
        mem_din = e.din;
        mem_done = 1'b1;
        if (!e.wr) begin
          done_t r;
          r.val = model_load(e.din, e.len, e.sgn);
          r.tag = e.tag;
          done_q.push_back(r);
        end
        @(posedge clk_in);
        #1;
        mem_done = 1'b0;
      end
    end
  end

  // Load-result monitor
  initial begin
    done_t r;
    forever begin
      @(negedge clk_in);
      if (done_signal === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got tag %0d value 0x%08h expected none", done_tag, done_value);
        end else begin
          r = done_q.pop_front();
          chk("done_value", done_value, r.val);
          chk("done_tag", done_tag, r.tag);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n_in = 0; rdy_in = 1; clear_in = 0; issue_signal = 0; issue_wr = 0; issue_signed = 0;
    issue_len = 0; issue_base = 0; issue_base_valid = 0; issue_base_tag = 0; issue_data = 0;
    issue_data_valid = 0; issue_data_tag = 0; issue_offset = 0; issue_rd_tag = 0;
    commit_signal = 0; commit_tag = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    mem_din = 0; mem_done = 0;
    repeat (2) tick;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_mem_signal", mem_signal, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done_signal, 0);
    rst_n_in = 1;
    tick;

    // LW with negative offset
    auto_mem = 1'b1;
    expect_op(1'b0, 2'b11, 32'h0000_0FFC, 32'h0, 32'hDEAD_BEEF, 4'd1, 1'b0);
    set_issue(1'b0, 1'b0, 2'b11, 32'h1000, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'hFFC, 4'd1);
    tick; issue_signal = 0;
    chk("lw_count", count, 1);
    wait_drain("lw", 50);

    // LB signed then LHU
    expect_op(1'b0, 2'b00, 32'h3000, 32'h0, 32'h0000_00F0, 4'd2, 1'b1);
    set_issue(1'b0, 1'b1, 2'b00, 32'h3000, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'h000, 4'd2);
    tick;
    expect_op(1'b0, 2'b01, 32'h3002, 32'h0, 32'h8001_ABCD, 4'd3, 1'b0);
    set_issue(1'b0, 1'b0, 2'b01, 32'h3000, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'h002, 4'd3);
    tick; issue_signal = 0;
    chk("lb_lhu_count", count, 2);
    wait_drain("lb_lhu", 60);

    // Store with both operands from the CDB; load capturing its base in the issue cycle
    expect_op(1'b1, 2'b11, 32'h2000, 32'h55, 32'h0, 4'd7, 1'b0);
    set_issue(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 4'd5, 32'h0, 1'b0, 4'd6, 12'h000, 4'd7);
    tick;
    expect_op(1'b0, 2'b11, 32'h2008, 32'h0, 32'h1234_5678, 4'd8, 1'b0);
    set_issue(1'b0, 1'b0, 2'b11, 32'h0, 1'b0, 4'd5, 32'h0, 1'b0, 4'd0, 12'h008, 4'd8);
    cdb_valid = 3'b111;
    cdb_tag   = {4'd5, 4'd6, 4'd6};
    cdb_value = {32'h0000_2000, 32'h0000_0099, 32'h0000_0055};
    tick; issue_signal = 0; cdb_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("st_wait_commit", mem_signal, 0);
    end
    commit(4'd7);
    wait_drain("cdb_store", 60);

    // Fill to the reserve threshold with loads that can never become ready
    auto_mem = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_issue(1'b0, 1'b0, 2'b11, 32'h0, 1'b0, 4'd15, 32'h0, 1'b0, 4'd0, 12'h0, 4'(8 + i));
      tick;
      if (i == 5) begin
        chk("fill6_count", count, 6);
        chk("fill6_full", full, 0);
      end
    end
    issue_signal = 0;
    chk("fill7_count", count, 7);
    chk("fill7_full", full, 1);
    chk("fill7_no_req", mem_signal, 0);
    clear_in = 1; tick; clear_in = 0;
    chk("flush_all_count", count, 0);
    chk("flush_all_full", full, 0);

    // Stall: nothing changes while rdy_in is low
    rdy_in = 0;
    set_issue(1'b0, 1'b0, 2'b11, 32'h40, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'h0, 4'd1);
    tick; tick;
    chk("stall_count", count, 0);
    issue_signal = 0; rdy_in = 1;
    tick;
    chk("stall_after_count", count, 0);

    // Flush keeps committed stores, store in flight completes
    set_issue(1'b1, 1'b0, 2'b11, 32'h100, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 12'h0, 4'd1);
    tick;
    set_issue(1'b1, 1'b0, 2'b11, 32'h104, 1'b1, 4'd0, 32'h22, 1'b1, 4'd0, 12'h0, 4'd2);
    commit_signal = 1; commit_tag = 4'd1;
    tick;
    set_issue(1'b0, 1'b0, 2'b11, 32'h200, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'h0, 4'd3);
    commit_tag = 4'd2;
    tick; commit_signal = 0;
    set_issue(1'b0, 1'b0, 2'b11, 32'h204, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'h0, 4'd4);
    tick;
    set_issue(1'b0, 1'b0, 2'b11, 32'h208, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 12'h0, 4'd5);
    tick; issue_signal = 0;
    chk("fl_count5", count, 5);
    wait_req("fl_s1_req");
    chk("fl_s1_addr", mem_addr, 32'h100);
    chk("fl_s1_wr", mem_wr, 1);
    clear_in = 1; tick; clear_in = 0;
    chk("fl_count2", count, 2);
    chk("fl_s1_still_req", mem_signal, 1);
    chk("fl_s1_addr_held", mem_addr, 32'h100);
    mem_done = 1; tick; mem_done = 0;
    chk("fl_count1", count, 1);
    wait_req("fl_s2_req");
    chk("fl_s2_addr", mem_addr, 32'h104);
    chk("fl_s2_wr", mem_wr, 1);
    chk("fl_s2_dout", mem_dout, 32'h22);
    mem_done = 1; tick; mem_done = 0;
    chk("fl_count0", count, 0);
    repeat (4) tick;
    chk("fl_no_req", mem_signal, 0);

    // Random traffic, 20 ops through the 8-deep queue
    auto_mem = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic        wr, sgn;
      logic [1:0]  len;
      logic [31:0] base, data, din;
      logic [11:0] off;
      logic [3:0]  tag;
      int          w;
      w = 0;
      while (full && w < 200) begin
        tick;
        w++;
      end
      if (w >= 200) begin
        checks++; errors++;
        $display("FAIL rand_full_timeout: got full=1 expected space");
      end
      repeat ($urandom_range(0, 2)) tick;
      wr   = ($urandom_range(0, 2) == 0);
      sgn  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       len = 2'b00;
        1:       len = 2'b01;
        default: len = 2'b11;
      endcase
      base = $urandom;
      data = $urandom;
      din  = $urandom;
      off  = 12'($urandom);
      tag  = 4'(n % 15);
      expect_op(wr, len, model_addr(base, off), data, din, tag, sgn);
      set_issue(wr, sgn, len, base, 1'b1, 4'd0, data, 1'b1, 4'd0, off, tag);
      tick; issue_signal = 0;
      if (wr) commit(tag);
    end
    wait_drain("random", 800);
    chk("rand_final_count", count, 0);
    chk("rand_done_q_empty", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lsq_multi_cdb.md
Name: lsq_multi_cdb

Overview:
- Parametrised successor of the in-order load/store buffer; sits between the issue stage/ROB and the memory controller.
- Holds up to LSQ_SIZE memory ops in a circular queue and executes them strictly in order from the head.
- Snoops CDB_PORTS result-broadcast channels, not two fixed ALU ports.
- New versus the previous generation: occupancy count, programmable almost-full reserve, in-block load sign/zero extension, and flush that preserves committed stores.

Parameters:
- LSQ_WIDTH, 3: log2 of queue depth.
- LSQ_SIZE, 2**LSQ_WIDTH: number of entries.
- ROB_WIDTH, 4: ROB tag width.
- CDB_PORTS, 3: number of snooped broadcast channels, 1..4.
- FULL_RESERVE, 1: free entries held back before `full` asserts.

Ports:
- clk_in in 1: system clock.
- rst_n_in in 1: reset, asynchronous, active-low.
- rdy_in in 1: global stall; when low, no state changes except async reset.
- clear_in in 1: misprediction flush.
- issue_signal in 1: push one op.
- issue_wr in 1: 1 = store.
- issue_signed in 1: signed load.
- issue_len in 2: 00 = byte, 01 = half, 11 = word.
- issue_base in 32: base value if valid.
- issue_base_valid in 1: base valid.
- issue_base_tag in ROB_WIDTH: producer tag of base.
- issue_data in 32: store data if valid.
- issue_data_valid in 1: store data valid.
- issue_data_tag in ROB_WIDTH: producer tag of store data.
- issue_offset in 12: signed immediate.
- issue_rd_tag in ROB_WIDTH: ROB tag of this op.
- commit_signal in 1: ROB commits a store.
- commit_tag in ROB_WIDTH: tag of the committed store.
- cdb_valid in CDB_PORTS: per-channel broadcast valid.
- cdb_tag in CDB_PORTS*ROB_WIDTH: packed tags, channel k at [k*ROB_WIDTH +: ROB_WIDTH].
- cdb_value in CDB_PORTS*32: packed values.
- mem_signal out 1: request valid, held until mem_done.
- mem_wr out 1: 1 = write.
- mem_len out 2: access length.
- mem_addr out 32: effective address.
- mem_dout out 32: store data.
- mem_din in 32: raw load word, byte 0 in [7:0].
- mem_done in 1: one-cycle completion pulse.
- done_signal out 1: load result valid, one-cycle pulse.
- done_value out 32: extended load result.
- done_tag out ROB_WIDTH: tag of the completed load.
- count out LSQ_WIDTH+1: occupied entries.
- full out 1: issue stage must not issue.

Behaviour:
- Reset (rst_n_in low, async): head = tail = 0, count = 0, all entries not busy, FSM = IDLE, mem_signal = 0, mem_wr = 0, mem_len = 0, mem_addr = 0, mem_dout = 0, done_signal = 0, done_value = 0, done_tag = 0.
- Reset asserted mid-request drops mem_signal immediately.
- Entry fields: busy, wr, signed, len, base + valid + tag, data + valid + tag, offset, rd_tag, committed.
- Entry ready:
  - Load: base_valid.
  - Store: base_valid & data_valid & committed.
- Issue: writes entry at tail, tail <= tail+1 (mod LSQ_SIZE).
- Same-cycle capture: an operand whose tag matches any valid CDB channel, or the load result being produced this cycle, is captured valid.
- Snoop: every cycle, each busy entry with an invalid operand captures a matching CDB value. Lowest channel index wins if duplicated.
- The block's own load result (done_*) is also snooped internally in the cycle it is produced.
- Commit: marks committed on the busy store with rd_tag == commit_tag. At most one match.
- full = (LSQ_SIZE - count) <= FULL_RESERVE.
- count tracks pushes/pops; a simultaneous push and pop leaves it unchanged.
- FSM, IDLE:
  - If head busy & ready, drive mem_* and go to REQ.
  - mem_addr = base + sign-extended offset, 32-bit wrap.
  - mem_dout = data.
  - First request appears 1 cycle after the head becomes ready.
- FSM, REQ:
  - Hold all mem_* stable until mem_done.
  - On mem_done: drop mem_signal, pop head, return to IDLE.
  - Next request no earlier than the following cycle.
- Load completion:
  - done_signal pulses in the cycle after mem_done.
  - done_value = mem_din[7:0] or mem_din[15:0], sign- or zero-extended per signed/len; len 11 passes through.
- Flush (clear_in & rdy_in):
  - Every entry that is not (store & committed) is freed; done_signal forced 0; issue in the same cycle is ignored.
  - Committed stores are contiguous from head; tail <= head + number of committed stores; count is updated to match.
  - In REQ for a load: request is cancelled and FSM goes to IDLE. The memory controller must accept the withdrawal.
  - In REQ for a store: the request continues to completion.
- Wrap-around: head/tail indices wrap mod LSQ_SIZE; count distinguishes empty from full.
- Issue while count == LSQ_SIZE is illegal; the push is dropped and an assertion flags it.

Test Plan:
- Reset then issue LW base = 0x1000 valid, offset = -4 (0xFFC) → mem_addr = 0x00000FFC, mem_len = 11; mem_din = 0xDEADBEEF with done → done_value = 0xDEADBEEF, done_tag = issue_rd_tag one cycle later.
- LB signed from mem_din = 0x000000F0 → done_value = 0xFFFFFFF0; LHU from 0x8001ABCD → 0x0000ABCD.
- Store with base tag 5 and data tag 6 invalid; cdb channel 2 broadcasts tag 5 = 0x2000, channel 0 broadcasts tag 6 = 0x55; no mem request until commit_tag matches → then mem_wr = 1, addr 0x2000, dout 0x55.
- LSQ_SIZE = 8, FULL_RESERVE = 1: seven issues with no completion → full = 1, count = 7.
- Two committed stores at head plus three loads, store 1 in REQ, assert clear_in → count = 2, store 1 still completes, store 2 issues next, no done_signal.
- Issue 20 ops through 8-deep queue with random mem_done delays → in-order completion, indices wrap, count returns to 0.
